// File: rtl/aes_key_schedule_pkg.sv
// Shared types and GF(2^8) helpers for the AES key-expansion block.
package aes_pkg;

  // Expansion controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Round constants, entry i at bits [8i+7:8i]; entry 0 is never used by the recurrence
  localparam logic [87:0] RCON_TABLE = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10,
    8'h08, 8'h04, 8'h02, 8'h01, 8'h00
  };

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    if (idx <= 4'd10) begin
      r = RCON_TABLE[{idx, 3'b000} +: 8];
    end else begin
      r = 8'h00;
    end
    return r;
  endfunction

  function automatic logic [3:0] nk_to_nr(input logic [3:0] nk);
    return nk + 4'd6;
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial
  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns on one column; byte 0 of the column lives in bits [7:0]
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int k = 0; k < 4; k++) begin
      a[k]  = col[8*k +: 8];
      m2[k] = gf_mul2(a[k]);
      m4[k] = gf_mul2(m2[k]);
      m8[k] = gf_mul2(m4[k]);
      m9[k] = m8[k] ^ a[k];
      mb[k] = m8[k] ^ m2[k] ^ a[k];
      md[k] = m8[k] ^ m4[k] ^ a[k];
      me[k] = m8[k] ^ m4[k] ^ m2[k];
    end
    return {mb[0] ^ md[1] ^ m9[2] ^ me[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            me[0] ^ mb[1] ^ md[2] ^ m9[3]};
  endfunction

endpackage

// File: rtl/aes_key_schedule_sbox.sv
// Four parallel AES forward S-box lookups (SubWord).
module aes_sbox (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  import aes_pkg::*;

  // Byte x of the table sits at bits [2047-8x -: 8]
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Independent lookup for each byte lane
  always_comb begin
    dout = 32'd0;
    for (int b = 0; b < 4; b++) begin
      dout[8*b +: 8] = SBOX_TABLE[(11'd2047 - {din[8*b +: 8], 3'b000}) -: 8];
    end
  end

endmodule

// File: rtl/aes_key_schedule.sv
// AES key expansion: one new schedule word per cycle, registered round-key readout
// with optional equivalent-inverse-cipher form.
module aes_key_schedule #(
  parameter int MAX_NK = 8,
  parameter int INV_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [32*MAX_NK-1:0]  CipherKey,
  input  logic                  k_ready,
  input  logic [3:0]            Nk,
  input  logic [3:0]            Addr,
  input  logic                  inv,
  output logic [127:0]          ex_key,
  output logic                  ex_valid,
  output logic                  busy,
  output logic                  err
);
  import aes_pkg::*;

  localparam int         DEPTH    = 4 * (MAX_NK + 7);
  localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);
  localparam logic       INV_ON   = (INV_EN != 0);

  logic [31:0]  w_q [DEPTH];
  state_e       state_q;
  logic [5:0]   cnt_q;
  logic [5:0]   nw_q;
  logic [3:0]   nk_q;
  logic [3:0]   nr_q;
  logic [2:0]   mod_q;
  logic [3:0]   rc_q;
  logic [127:0] ex_key_q;
  logic         ex_valid_q;
  logic         busy_q;
  logic         err_q;

  logic         load_legal_s;
  logic         load_bad_s;
  logic [5:0]   prev_idx_s;
  logic [5:0]   back_idx_s;
  logic [31:0]  prev_word_s;
  logic [31:0]  back_word_s;
  logic [31:0]  sub_in_s;
  logic [31:0]  sub_out_s;
  logic [31:0]  temp_s;
  logic [31:0]  new_word_s;
  logic         rd_ok_s;
  logic         inv_sel_s;
  logic [5:0]   rd_base_s;
  logic [31:0]  rd_word_s;
  logic [127:0] ex_key_d;

  assign ex_key   = ex_key_q;
  assign ex_valid = ex_valid_q;
  assign busy     = busy_q;
  assign err      = err_q;

  // Classify a k_ready pulse as a legal or rejected load
  always_comb begin
    load_legal_s = 1'b0;
    load_bad_s   = 1'b0;
    if (k_ready) begin
      load_legal_s = ((Nk == 4'd4) || (Nk == 4'd6) || (Nk == 4'd8)) && (Nk <= MAX_NK_W);
      load_bad_s   = !load_legal_s;
    end else begin
      load_legal_s = 1'b0;
      load_bad_s   = 1'b0;
    end
  end

  // Fetch w[i-1] and w[i-Nk] for the word being generated
  always_comb begin
    prev_idx_s = 6'd0;
    back_idx_s = 6'd0;
    if (state_q == ST_EXPAND) begin
      prev_idx_s = cnt_q - 6'd1;
      back_idx_s = cnt_q - {2'b00, nk_q};
    end else begin
      prev_idx_s = 6'd0;
      back_idx_s = 6'd0;
    end
    prev_word_s = w_q[prev_idx_s];
    back_word_s = w_q[back_idx_s];
  end

  // SubWord input: rotated word at the start of each Nk group, plain word otherwise
  always_comb begin
    if (mod_q == 3'd0) begin
      sub_in_s = {prev_word_s[7:0], prev_word_s[31:8]};
    end else begin
      sub_in_s = prev_word_s;
    end
  end

  aes_sbox u_sbox (
    .din  (sub_in_s),
    .dout (sub_out_s)
  );

  // Recurrence temp value and the new schedule word
  always_comb begin
    if (mod_q == 3'd0) begin
      temp_s = sub_out_s ^ {24'd0, rcon(rc_q)};
    end else if ((nk_q == 4'd8) && (mod_q == 3'd4)) begin
      temp_s = sub_out_s;
    end else begin
      temp_s = prev_word_s;
    end
    new_word_s = back_word_s ^ temp_s;
  end

  // Round-key availability: all four words must already be written
  always_comb begin
    if (state_q != ST_IDLE) begin
      rd_ok_s = (Addr <= nr_q) && (({1'b0, Addr, 2'b00} + 7'd4) <= {1'b0, cnt_q});
    end else begin
      rd_ok_s = 1'b0;
    end
    inv_sel_s = INV_ON && inv && (Addr != 4'd0) && (Addr != nr_q);
  end

  // Assemble the round key, applying InvMixColumns to middle rounds when selected
  always_comb begin
    ex_key_d  = 128'd0;
    rd_base_s = 6'd0;
    rd_word_s = 32'd0;
    if (rd_ok_s) begin
      rd_base_s = {Addr, 2'b00};
      for (int j = 0; j < 4; j++) begin
        rd_word_s = w_q[rd_base_s + 6'(j)];
        if (inv_sel_s) begin
          ex_key_d[32*j +: 32] = inv_mix_col(rd_word_s);
        end else begin
          ex_key_d[32*j +: 32] = rd_word_s;
        end
      end
    end else begin
      ex_key_d = 128'd0;
    end
  end

  // Word storage: key words on load, one expanded word per EXPAND cycle
  always_ff @(posedge clk) begin
    if (rst_n && load_legal_s) begin
      for (int j = 0; j < MAX_NK; j++) begin
        w_q[6'(j)] <= CipherKey[32*j +: 32];
      end
    end else if (rst_n && (state_q == ST_EXPAND)) begin
      w_q[cnt_q] <= new_word_s;
    end
  end

  // Controller: state, counters and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 6'd0;
      nw_q       <= 6'd44;
      nk_q       <= 4'd4;
      nr_q       <= 4'd10;
      mod_q      <= 3'd0;
      rc_q       <= 4'd1;
      ex_key_q   <= 128'd0;
      ex_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q      <= load_bad_s;
      ex_key_q   <= ex_key_d;
      ex_valid_q <= rd_ok_s;
      if (load_legal_s) begin
        state_q <= ST_EXPAND;
        busy_q  <= 1'b1;
        cnt_q   <= {2'b00, Nk};
        nk_q    <= Nk;
        nr_q    <= nk_to_nr(Nk);
        nw_q    <= {nk_to_nr(Nk) + 4'd1, 2'b00};
        mod_q   <= 3'd0;
        rc_q    <= 4'd1;
      end else begin
        case (state_q)
          ST_EXPAND: begin
            cnt_q <= cnt_q + 6'd1;
            if ({1'b0, mod_q} == (nk_q - 4'd1)) begin
              mod_q <= 3'd0;
              rc_q  <= (rc_q < 4'd10) ? (rc_q + 4'd1) : rc_q;
            end else begin
              mod_q <= mod_q + 3'd1;
            end
            if (cnt_q == (nw_q - 6'd1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
            end
          end
          ST_DONE: begin
            busy_q <= 1'b0;
          end
          ST_IDLE: begin
            busy_q <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule using FIPS-197 appendix A vectors.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] cipher_key;
  logic         k_ready;
  logic [3:0]   nk;
  logic [3:0]   addr;
  logic         inv;
  logic [127:0] ex_key;
  logic         ex_valid;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic         valid;
  } exp_t;

  exp_t sb[$];

  aes_key_schedule #(.MAX_NK(8), .INV_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .CipherKey (cipher_key),
    .k_ready   (k_ready),
    .Nk        (nk),
    .Addr      (addr),
    .inv       (inv),
    .ex_key    (ex_key),
    .ex_valid  (ex_valid),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] A2_KEY = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] A3_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  // Byte string (first byte most significant) to key-port layout (byte 0 in bits [7:0])
  function automatic logic [255:0] mk_key(input logic [255:0] s, input int nb);
    logic [255:0] r = '0;
    for (int k = 0; k < nb; k++) r[8*k +: 8] = s[8*(nb-1-k) +: 8];
    return r;
  endfunction

  function automatic logic [127:0] rk(input logic [127:0] s);
    logic [127:0] r = '0;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = s[8*(15-k) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] imc(input logic [127:0] k);
    logic [7:0]   c [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [127:0] r = '0;
    logic [7:0]   acc;
    for (int col = 0; col < 4; col++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int kk = 0; kk < 4; kk++) acc ^= gmul(c[(kk - row + 4) % 4], k[32*col + 8*kk +: 8]);
        r[32*col + 8*row +: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] a1_round(input int r);
    case (r)
      0:  return rk(128'h2b7e151628aed2a6abf7158809cf4f3c);
      1:  return rk(128'ha0fafe1788542cb123a339392a6c7605);
      2:  return rk(128'hf2c295f27a96b9435935807a7359f67f);
      9:  return rk(128'hac7766f319fadc2128d12941575c006e);
      10: return rk(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      default: return 128'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [255:0] key, input logic [3:0] n);
    cipher_key = key;
    nk         = n;
    k_ready    = 1'b1;
    tick();
    k_ready    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ex_valid); end
    n_checks++; if (ex_key !== 128'd0) begin n_fail++; $display("FAIL reset_key got %h want 0", ex_key); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_aes128();
    int n = 0;
    int rounds [5] = '{0, 1, 2, 9, 10};
    exp_t e;
    do_load(mk_key(256'(A1_KEY), 16), 4'd4);
    for (int c = 0; c < 100 && busy === 1'b1; c++) begin n++; tick(); end
    n_checks++; if (n != 40) begin n_fail++; $display("FAIL aes128_busy_cycles got %0d want 40", n); end
    for (int i = 0; i < 5; i++) begin
      addr = 4'(rounds[i]);
      sb.push_back('{$sformatf("aes128_rk%0d", rounds[i]), a1_round(rounds[i]), 1'b1});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (ex_valid !== e.valid || ex_key !== e.key) begin
        n_fail++; $display("FAIL %s got %b/%h want %b/%h", e.name, ex_valid, ex_key, e.valid, e.key);
      end
    end
  endtask

  task automatic test_aes192();
    int n = 0;
    int addrs [2] = '{12, 13};
    exp_t e;
    do_load(mk_key(256'(A2_KEY), 24), 4'd6);
    for (int c = 0; c < 100 && busy === 1'b1; c++) begin n++; tick(); end
    n_checks++; if (n != 46) begin n_fail++; $display("FAIL aes192_busy_cycles got %0d want 46", n); end
    sb.push_back('{"aes192_rk12", rk(128'he98ba06f448c773c8ecc720401002202), 1'b1});
    sb.push_back('{"aes192_rk13_invalid", 128'd0, 1'b0});
    for (int i = 0; i < 2; i++) begin
      addr = 4'(addrs[i]);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (ex_valid !== e.valid || ex_key !== e.key) begin
        n_fail++; $display("FAIL %s got %b/%h want %b/%h", e.name, ex_valid, ex_key, e.valid, e.key);
      end
    end
  endtask

  task automatic test_aes256();
    int n = 0;
    int addrs [2] = '{14, 15};
    exp_t e;
    do_load(mk_key(A3_KEY, 32), 4'd8);
    for (int c = 0; c < 100 && busy === 1'b1; c++) begin n++; tick(); end
    n_checks++; if (n != 52) begin n_fail++; $display("FAIL aes256_busy_cycles got %0d want 52", n); end
    sb.push_back('{"aes256_rk14", rk(128'hfe4890d1e6188d0b046df344706c631e), 1'b1});
    sb.push_back('{"aes256_rk15_invalid", 128'd0, 1'b0});
    for (int i = 0; i < 2; i++) begin
      addr = 4'(addrs[i]);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (ex_valid !== e.valid || ex_key !== e.key) begin
        n_fail++; $display("FAIL %s got %b/%h want %b/%h", e.name, ex_valid, ex_key, e.valid, e.key);
      end
    end
  endtask

  // Hold an address during expansion and check the exact cycle it becomes valid
  task automatic test_poll();
    exp_t e;
    addr = 4'd10;
    do_load(mk_key(256'(A1_KEY), 16), 4'd4);
    for (int k = 1; k <= 44; k++) begin
      sb.push_back('{$sformatf("poll_a10_T+%0d", k), (k >= 41) ? a1_round(10) : 128'd0, k >= 41});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (ex_valid !== e.valid || ex_key !== e.key) begin
        n_fail++; $display("FAIL %s got %b/%h want %b/%h", e.name, ex_valid, ex_key, e.valid, e.key);
      end
    end
    addr = 4'd1;
    do_load(mk_key(256'(A1_KEY), 16), 4'd4);
    for (int k = 1; k <= 7; k++) begin
      sb.push_back('{$sformatf("poll_a1_T+%0d", k), (k >= 5) ? a1_round(1) : 128'd0, k >= 5});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (ex_valid !== e.valid || ex_key !== e.key) begin
        n_fail++; $display("FAIL %s got %b/%h want %b/%h", e.name, ex_valid, ex_key, e.valid, e.key);
      end
    end
  endtask

  task automatic test_restart();
    int n = 0;
    logic [127:0] rk14 = rk(128'hfe4890d1e6188d0b046df344706c631e);
    exp_t e;
    do_load(mk_key(A3_KEY, 32), 4'd8);
    for (int c = 1; c < 20; c++) tick();
    addr = 4'd2;
    do_load(mk_key(A3_KEY, 32), 4'd8);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got %b want 1", busy); end
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL restart_old_words got %b want 0", ex_valid); end
    addr = 4'd14;
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL restart_a14 got %b want 0", ex_valid); end
    for (int c = 0; c < 100 && busy === 1'b1; c++) begin n++; tick(); end
    n_checks++; if (n != 50) begin n_fail++; $display("FAIL restart_busy_cycles got %0d want 50", n); end
    sb.push_back('{"restart_rk14", rk14, 1'b1});
    tick();
    e = sb.pop_front();
    n_checks++;
    if (ex_valid !== e.valid || ex_key !== e.key) begin
      n_fail++; $display("FAIL %s got %b/%h want %b/%h", e.name, ex_valid, ex_key, e.valid, e.key);
    end
    // Illegal loads: Nk=5 and Nk=10 must pulse err and disturb nothing
    for (int i = 0; i < 2; i++) begin
      cipher_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      nk         = (i == 0) ? 4'd5 : 4'd10;
      k_ready    = 1'b1;
      sb.push_back('{$sformatf("illegal%0d_rk14", i), rk14, 1'b1});
      tick();
      k_ready = 1'b0;
      e = sb.pop_front();
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal%0d_err got %b want 1", i, err); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL illegal%0d_busy got %b want 0", i, busy); end
      n_checks++;
      if (ex_valid !== e.valid || ex_key !== e.key) begin
        n_fail++; $display("FAIL %s got %b/%h want %b/%h", e.name, ex_valid, ex_key, e.valid, e.key);
      end
      tick();
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL illegal%0d_err_clear got %b want 0", i, err); end
    end
  endtask

  task automatic test_inv();
    int n = 0;
    int addrs [4] = '{0, 1, 9, 10};
    exp_t e;
    do_load(mk_key(256'(A1_KEY), 16), 4'd4);
    for (int c = 0; c < 100 && busy === 1'b1; c++) begin n++; tick(); end
    n_checks++; if (n != 40) begin n_fail++; $display("FAIL inv_busy_cycles got %0d want 40", n); end
    inv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 4'(addrs[i]);
      if (addrs[i] == 0 || addrs[i] == 10)
        sb.push_back('{$sformatf("inv_rk%0d", addrs[i]), a1_round(addrs[i]), 1'b1});
      else
        sb.push_back('{$sformatf("inv_rk%0d", addrs[i]), imc(a1_round(addrs[i])), 1'b1});
      tick();
      e = sb.pop_front();
      n_checks++;
      if (ex_valid !== e.valid || ex_key !== e.key) begin
        n_fail++; $display("FAIL %s got %b/%h want %b/%h", e.name, ex_valid, ex_key, e.valid, e.key);
      end
    end
    inv = 1'b0;
  endtask

  task automatic test_reset_mid();
    addr = 4'd0;
    do_load(mk_key(256'(A1_KEY), 16), 4'd4);
    for (int c = 0; c < 10; c++) tick();
    rst_n      = 1'b0;
    k_ready    = 1'b1;
    tick();
    rst_n   = 1'b1;
    k_ready = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", ex_valid); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (ex_valid !== 1'b0 || busy !== 1'b0 || ex_key !== 128'd0) begin
        n_fail++; $display("FAIL rstmid_idle%0d got v=%b b=%b k=%h want 0/0/0", c, ex_valid, busy, ex_key);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    cipher_key = '0;
    k_ready    = 1'b0;
    nk         = 4'd4;
    addr       = 4'd0;
    inv        = 1'b0;
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_poll();
    test_restart();
    test_inv();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 The block SHALL have parameter MAX_NK, default 8, giving the largest supported key length in 32-bit words (legal values 4, 6, 8).
REQ-002 The block SHALL have parameter INV_EN, default 1, which when 1 enables equivalent-inverse-cipher round-key output.
REQ-003 clk  input  1  single clock; all logic is rising-edge triggered.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 CipherKey  input  32*MAX_NK  cipher key; word j = CipherKey[32j+31:32j]; byte 0 of each word in bits [7:0].
REQ-006 k_ready  input  1  a one-cycle pulse that starts a key load.
REQ-007 Nk  input  4  key length in words (4, 6 or 8), sampled with k_ready.
REQ-008 Addr  input  4  round-key index, 0..Nr.
REQ-009 inv  input  1  selects the inverse-cipher key form; ignored when INV_EN=0.
REQ-010 ex_key  output  128  round key; word 0 in [31:0].
REQ-011 ex_valid  output  1  ex_key holds a fully generated key for Addr.
REQ-012 busy  output  1  expansion in progress.
REQ-013 err  output  1  one-cycle pulse flagging a rejected load.

Function
REQ-014 States SHALL be IDLE, EXPAND and DONE; reset enters IDLE.
REQ-015 A load is legal when k_ready=1, Nk is 4, 6 or 8, and Nk<=MAX_NK; Nr=Nk+6 and Nw=4*(Nr+1), giving 44, 52 or 60 words.
REQ-016 On a legal load at edge T, words 0..Nk-1 SHALL be stored, Nk and Nr latched, and the state SHALL become EXPAND.
REQ-017 In EXPAND, word i (starting at Nk) SHALL be written at edge T+(i-Nk+1), one word per cycle, using the FIPS-197 recurrence.
REQ-018 The recurrence SHALL apply RotWord+SubWord+Rcon[i/Nk] when i mod Nk=0, and SubWord only when Nk=8 and i mod 8=4.
REQ-019 After word Nw-1 is written the state SHALL be DONE: AES-128 at T+40, AES-192 at T+46, AES-256 at T+52.
REQ-020 busy SHALL be 1 exactly in EXPAND.
REQ-021 A legal load in any state, including mid-EXPAND, SHALL abort the current expansion and restart; all prior words are treated as ungenerated.
REQ-022 An illegal load SHALL pulse err on the next cycle and leave all state unchanged.
REQ-023 Readout SHALL be registered: ex_key and ex_valid reflect the Addr and inv sampled at the previous edge.
REQ-024 ex_valid SHALL be 1 iff Addr<=Nr and words 4*Addr..4*Addr+3 were all written before the sampling edge; otherwise ex_key SHALL be 0.
REQ-025 When inv=1 and INV_EN=1, rounds 1..Nr-1 SHALL be output as InvMixColumns applied to each word; rounds 0 and Nr SHALL be output unchanged.
REQ-026 The Rcon index SHALL never exceed 10; the word counter SHALL be 6 bits and SHALL not wrap.

Reset
REQ-027 rst_n=0 at an edge SHALL set state IDLE, word count 0, and ex_key, ex_valid, busy and err to 0; stored words need not clear.
REQ-028 Reset asserted mid-EXPAND SHALL take priority over k_ready, and ex_valid SHALL stay 0 until a new load.

Structure
REQ-029 Package aes_pkg SHALL hold the Rcon table, the state enum, the Nk-to-Nr function, and a gf_mul2 helper.
REQ-030 One sub-module, aes_sbox (32-bit, 4 parallel S-box lookups), SHALL be instantiated once for SubWord.
REQ-031 Word storage SHALL be a 4*(MAX_NK+7)-entry by 32-bit register array.

Verification
REQ-032 FIPS-197 A.1 key 2b7e1516..09cf4f3c, Nk=4 -> busy for 40 cycles; Addr=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6 (byte string), ex_valid=1.
REQ-033 A.2 key 8e73b0f7..522c6b7b, Nk=6 -> Addr=12 gives e98ba06f448c773c8ecc720401002202 after 46 cycles.
REQ-034 A.3 key 603deb10..0914dff4, Nk=8 -> Addr=14 gives fe4890d1e6188d0b046df344706c631e; Addr=15 -> ex_valid=0, ex_key=0.
REQ-035 Poll Addr=10 during the A.1 expansion -> ex_valid rises exactly one cycle after word 43 is written; Addr=1 is valid from T+5.
REQ-036 A legal load at cycle 20 of an AES-256 expansion restarts the count (busy continues, Addr=14 invalid); Nk=5 -> err pulse with no state change.
REQ-037 A.1 with inv=1 -> Addr 0 and 10 match forward; Addr 9 = InvMixColumns(ac7766f319fadc2128d12941575c006e); rst_n=0 mid-run -> IDLE with ex_valid=0.
